// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC3 instruction fetch unit.
package lc3_fetch_pkg;

  typedef logic [15:0] bit_16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } fetch_state_t;

  localparam bit_16 LC3_RESET_PC = 16'h3000;

endpackage

// File: rtl/lc3_fetch_unit.sv
// LC3 fetch unit: owns the PC, issues one instruction-memory read at a time,
// holds the result in IR for decode, and handles redirects and request timeouts.
//
// Handshake: IR is transferred to decode on a cycle where ir_valid and ir_ready
// are both high at the rising edge; ir_valid stays high (IR/npc_out stable)
// until then, and drops early only on a redirect or reset.
module lc3_fetch_unit
  import lc3_fetch_pkg::*;
#(
  parameter bit_16       RESET_PC = LC3_RESET_PC,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic         clock,
  input  logic         reset,
  output bit_16        PC,
  output logic         instrmem_rd,
  input  bit_16        instr_dout,
  input  logic         complete_instr,
  output bit_16        IR,
  output bit_16        npc_out,
  output logic         ir_valid,
  input  logic         ir_ready,
  input  logic         br_taken,
  input  bit_16        taken_address,
  output logic         fetch_err,
  output bit_16        fetch_count,
  output fetch_state_t fsm_state
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  fetch_state_t  state, state_n;
  bit_16         pc_n, ir_n, npc_n, count_n;
  logic          rd_n, valid_n, err_n;
  logic [CW-1:0] wait_cnt, wait_n;

  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      PC          <= RESET_PC;
      instrmem_rd <= 1'b0;
      IR          <= '0;
      npc_out     <= '0;
      ir_valid    <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_count <= '0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_n;
      PC          <= pc_n;
      instrmem_rd <= rd_n;
      IR          <= ir_n;
      npc_out     <= npc_n;
      ir_valid    <= valid_n;
      fetch_err   <= err_n;
      fetch_count <= count_n;
      wait_cnt    <= wait_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = PC;
    rd_n    = instrmem_rd;
    ir_n    = IR;
    npc_n   = npc_out;
    valid_n = ir_valid;
    err_n   = fetch_err;
    count_n = fetch_count;
    wait_n  = wait_cnt;

    // A redirect wins over everything except the idle start-up cycle;
    // any response arriving alongside it is dropped.
    if (br_taken && state != S_IDLE) begin
      if (state == S_HOLD && ir_ready) begin
        count_n = fetch_count + 16'd1;
      end
      pc_n    = taken_address;
      valid_n = 1'b0;
      rd_n    = 1'b0;
      wait_n  = '0;
      state_n = S_FLUSH;
    end else begin
      unique case (state)
        S_IDLE: begin
          rd_n    = 1'b1;
          state_n = S_REQ;
        end
        S_REQ: begin
          if (complete_instr) begin
            ir_n    = instr_dout;
            npc_n   = PC + 16'd1;
            rd_n    = 1'b0;
            valid_n = 1'b1;
            wait_n  = '0;
            state_n = S_HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            // Give up on this request; the same PC is re-issued after a flush.
            err_n   = 1'b1;
            rd_n    = 1'b0;
            wait_n  = '0;
            state_n = S_FLUSH;
          end else begin
            wait_n = wait_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (ir_ready) begin
            valid_n = 1'b0;
            count_n = fetch_count + 16'd1;
            pc_n    = PC + 16'd1;
            rd_n    = 1'b1;
            state_n = S_REQ;
          end
        end
        S_FLUSH: begin
          rd_n    = 1'b1;
          state_n = S_REQ;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Directed plus randomized bench for lc3_fetch_unit against a cycle reference
// model that tracks the visible outputs and derives the fetch phase from them.
module tb_lc3_fetch_unit;
  import lc3_fetch_pkg::*;

  localparam int TO = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  bit_16        PC, IR, npc_out, fetch_count, instr_dout, taken_address;
  logic         instrmem_rd, complete_instr, ir_valid, ir_ready, br_taken, fetch_err;
  fetch_state_t fsm_state;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  bit_16 m_pc, m_ir, m_npc, m_count;
  logic  m_rd, m_valid, m_err, m_idle;
  int    m_wait;

  always #5 clock = ~clock;

  lc3_fetch_unit #(.RESET_PC(16'h3000), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .PC(PC), .instrmem_rd(instrmem_rd),
    .instr_dout(instr_dout), .complete_instr(complete_instr), .IR(IR),
    .npc_out(npc_out), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .br_taken(br_taken), .taken_address(taken_address), .fetch_err(fetch_err),
    .fetch_count(fetch_count), .fsm_state(fsm_state)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model of one rising edge, written from the behavioural rules.
  task automatic model_edge(input logic rst, input logic cpl, input bit_16 data,
                            input logic rdy, input logic br, input bit_16 addr);
    if (!rst) begin
      m_pc = 16'h3000; m_rd = 0; m_ir = 0; m_npc = 0; m_valid = 0;
      m_err = 0; m_count = 0; m_wait = 0; m_idle = 1;
    end else if (m_idle) begin
      m_rd = 1; m_idle = 0;
    end else if (br) begin
      if (m_valid && rdy) m_count++;
      m_pc = addr; m_valid = 0; m_rd = 0; m_wait = 0;
    end else if (m_rd) begin
      if (cpl) begin
        m_ir = data; m_npc = m_pc + 16'd1; m_rd = 0; m_valid = 1; m_wait = 0;
      end else if (m_wait == TO - 1) begin
        m_err = 1; m_rd = 0; m_wait = 0;
      end else begin
        m_wait++;
      end
    end else if (m_valid) begin
      if (rdy) begin
        m_valid = 0; m_count++; m_pc = m_pc + 16'd1; m_rd = 1;
      end
    end else begin
      m_rd = 1;
    end
  endtask

  task automatic check_model();
    chk("pc", PC, m_pc);
    chk("rd", {15'd0, instrmem_rd}, {15'd0, m_rd});
    chk("ir", IR, m_ir);
    chk("npc", npc_out, m_npc);
    chk("valid", {15'd0, ir_valid}, {15'd0, m_valid});
    chk("err", {15'd0, fetch_err}, {15'd0, m_err});
    chk("count", fetch_count, m_count);
  endtask

  // Drive inputs, clock once, advance the model, check #1 after the edge.
  task automatic step(input logic rst, input logic cpl, input bit_16 data,
                      input logic rdy, input logic br, input bit_16 addr);
    reset = rst; complete_instr = cpl; instr_dout = data;
    ir_ready = rdy; br_taken = br; taken_address = addr;
    @(posedge clock);
    model_edge(rst, cpl, data, rdy, br, addr);
    #1;
    check_model();
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    bit_16 ir_keep;
    complete_instr = 0; instr_dout = 0; ir_ready = 0; br_taken = 0; taken_address = 0;

    // reset sequence
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("rst_pc", PC, 16'h3000);
    chk("rst_rd", {15'd0, instrmem_rd}, 16'd0);
    chk("rst_state", {14'd0, fsm_state}, {14'd0, S_IDLE});
    idle_step();
    chk("first_rd", {15'd0, instrmem_rd}, 16'd1);

    // basic fetch, response two cycles after rd
    idle_step(); idle_step();
    step(1'b1, 1'b1, 16'h1261, 1'b1, 1'b0, 16'h0);
    chk("basic_ir", IR, 16'h1261);
    chk("basic_npc", npc_out, 16'h3001);
    chk("basic_valid", {15'd0, ir_valid}, 16'd1);
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    chk("basic_pc", PC, 16'h3001);
    chk("basic_rd", {15'd0, instrmem_rd}, 16'd1);
    chk("basic_cnt", fetch_count, 16'd1);

    // backpressure
    step(1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h0);
    ir_keep = IR;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      chk("bp_ir", IR, 16'h5A5A);
      chk("bp_valid", {15'd0, ir_valid}, 16'd1);
      chk("bp_rd", {15'd0, instrmem_rd}, 16'd0);
    end
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    chk("bp_pc", PC, 16'h3002);
    idle_step();
    chk("bp_pc_once", PC, 16'h3002);

    // redirect collides with a response
    step(1'b1, 1'b1, 16'hABCD, 1'b0, 1'b1, 16'h4000);
    chk("col_ir", IR, ir_keep);
    chk("col_rd", {15'd0, instrmem_rd}, 16'd0);
    idle_step();
    chk("col_pc", PC, 16'h4000);
    chk("col_rd1", {15'd0, instrmem_rd}, 16'd1);

    // timeout: 16 unanswered cycles in the request phase
    for (int i = 0; i < TO - 1; i++) idle_step();
    chk("to_err_early", {15'd0, fetch_err}, 16'd0);
    idle_step();
    chk("to_err", {15'd0, fetch_err}, 16'd1);
    chk("to_rd0", {15'd0, instrmem_rd}, 16'd0);
    idle_step();
    chk("to_rd1", {15'd0, instrmem_rd}, 16'd1);
    chk("to_pc", PC, 16'h4000);

    // wrap-around at the top of memory
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'hFFFF);
    idle_step();
    step(1'b1, 1'b1, 16'h0F0F, 1'b0, 1'b0, 16'h0);
    chk("wrap_npc", npc_out, 16'h0000);
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    chk("wrap_pc", PC, 16'h0000);
    chk("sticky_err", {15'd0, fetch_err}, 16'd1);

    // reset in the middle of a request
    step(1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0);
    chk("mid_pc", PC, 16'h3000);
    chk("mid_rd", {15'd0, instrmem_rd}, 16'd0);
    chk("mid_valid", {15'd0, ir_valid}, 16'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) == 0),
           16'($urandom()),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 19) == 0),
           16'($urandom()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_fetch_unit.md
Name: lc3_fetch_unit

Overview:
- Upstream neighbour of the instruction-memory port. It owns the LC3 program counter and drives PC and instrmem_rd onto inst_mem_if.
- It waits for complete_instr and captures instr_dout into an instruction register (IR).
- It hands IR to decode through a valid/ready handshake.
- It handles branch/jump redirects, plus a request timeout with retry.

Parameters:
- RESET_PC, 16'h3000, PC value loaded on reset.
- TIMEOUT, 16, number of cycles S_REQ waits for complete_instr before a retry.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- PC  output  16  instruction address, registered.
- instrmem_rd  output  1  read request, registered.
- instr_dout  input  16  instruction data from memory.
- complete_instr  input  1  memory response strobe.
- IR  output  16  captured instruction.
- npc_out  output  16  PC+1 of the instruction held in IR, registered.
- ir_valid  output  1  IR holds an unconsumed instruction.
- ir_ready  input  1  decode accepts IR.
- br_taken  input  1  redirect request.
- taken_address  input  16  redirect target.
- fetch_err  output  1  sticky timeout flag.
- fetch_count  output  16  count of instructions accepted by decode; wraps.

Behaviour:
- Reset:
  - reset==0 at a posedge forces: PC=RESET_PC, instrmem_rd=0, IR=0, npc_out=0, ir_valid=0, fetch_err=0, fetch_count=0, wait counter=0, state=S_IDLE.
  - Reset asserted in any state aborts the operation in progress. A pending memory response is dropped.
- States: S_IDLE, S_REQ, S_HOLD, S_FLUSH.
- S_IDLE:
  - Entered only by reset.
  - First cycle with reset==1: instrmem_rd<=1, go S_REQ.
- S_REQ:
  - instrmem_rd=1; PC stable.
  - complete_instr is sampled each posedge. It is ignored in every other state.
  - On complete_instr==1: IR<=instr_dout, npc_out<=PC+1, instrmem_rd<=0, ir_valid<=1, wait counter<=0, go S_HOLD.
  - Minimum latency is rd asserted to ir_valid in 1 cycle after the complete_instr sample.
  - Otherwise the wait counter increments.
  - When the counter reaches TIMEOUT-1 without a response: fetch_err<=1, instrmem_rd<=0, counter<=0, go S_FLUSH. The same PC is retried.
- S_HOLD:
  - ir_valid=1; IR and npc_out stable; instrmem_rd=0.
  - On ir_ready==1: ir_valid<=0, fetch_count<=fetch_count+1, PC<=PC+1, instrmem_rd<=1, go S_REQ.
  - PC arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000.
- S_FLUSH:
  - instrmem_rd=0 for exactly one cycle, then instrmem_rd<=1, go S_REQ.
- Redirect:
  - br_taken==1 in S_REQ, S_HOLD or S_FLUSH causes: PC<=taken_address, ir_valid<=0, instrmem_rd<=0, counter<=0, go S_FLUSH.
  - Redirect has priority over complete_instr in the same cycle. That response data is discarded and IR is not updated.
  - Redirect in S_HOLD together with ir_ready==1: the instruction counts as accepted (fetch_count increments). PC still loads taken_address, not PC+1.
  - br_taken is ignored in S_IDLE.
- Handshake rule: ir_valid never deasserts without ir_ready, except on redirect or reset.
- fetch_err clears only on reset.
- Exactly one outstanding request at a time.

Decomposition:
- Shared package lc3_fetch_pkg holds:
  - fetch_state_t enum (S_IDLE, S_REQ, S_HOLD, S_FLUSH);
  - bit_16 typedef, reused from the existing LC3 typedefs;
  - LC3_RESET_PC constant, 16'h3000.
- No sub-module; the wait counter and PC incrementer stay inline.

Test Plan:
- Reset sequence: hold reset=0 for 3 cycles, then release.
  - Expect PC=16'h3000 and instrmem_rd=0 during reset.
  - Expect instrmem_rd=1 on the first cycle after release.
- Basic fetch: complete_instr=1 with instr_dout=16'h1261, 2 cycles after rd, ir_ready=1.
  - Expect IR=16'h1261, npc_out=16'h3001, ir_valid for 1 cycle.
  - Then PC=16'h3001 with rd reasserted; fetch_count=1.
- Backpressure: ir_ready=0 for 5 cycles after a capture.
  - Expect ir_valid and IR to stay constant and instrmem_rd=0.
  - After ir_ready=1, PC advances exactly once.
- Redirect collision: br_taken=1 with taken_address=16'h4000 in the same cycle as complete_instr (instr_dout=16'hABCD).
  - Expect IR unchanged and one cycle with rd=0.
  - Expect PC=16'h4000 and rd=1 the cycle after.
- Timeout: never assert complete_instr.
  - Expect fetch_err=1 after 16 cycles in S_REQ, one rd=0 cycle, then rd=1 again at the same PC.
  - fetch_err stays 1 until reset.
- Wrap-around and mid-operation reset: redirect to 16'hFFFF, then fetch and accept.
  - Expect next PC=16'h0000.
  - Assert reset=0 while in S_REQ: expect PC=16'h3000, rd=0, ir_valid=0 on the next cycle.
